// File: rtl/axi_mem_responder_if.sv
// AXI4 bus bundle between a master and axi_mem_responder.
// Groups AW, W, B, AR and R channel signals; clk/rst stay outside.
//   slave  modport : responder side (accepts AW/W/AR, drives B/R)
//   master modport : requester side (drives AW/W/AR, accepts B/R)
interface axi_mem_responder_if #(
  parameter int unsigned AXI_ID_WIDTH   = 5,
  parameter int unsigned AXI_LEN_WIDTH  = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64
) ();

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   axi_awid;
  logic [AXI_ADDR_WIDTH-1:0] axi_awaddr;
  logic [AXI_LEN_WIDTH-1:0]  axi_awlen;
  logic [1:0]                axi_awburst;
  logic                      axi_awvalid;
  logic                      axi_awready;

  logic [AXI_DATA_WIDTH-1:0] axi_wdata;
  logic [STRB_W-1:0]         axi_wstrb;
  logic                      axi_wlast;
  logic                      axi_wvalid;
  logic                      axi_wready;

  logic [AXI_ID_WIDTH-1:0]   axi_bid;
  logic [1:0]                axi_bresp;
  logic                      axi_bvalid;
  logic                      axi_bready;

  logic [AXI_ID_WIDTH-1:0]   axi_arid;
  logic [AXI_ADDR_WIDTH-1:0] axi_araddr;
  logic [AXI_LEN_WIDTH-1:0]  axi_arlen;
  logic [1:0]                axi_arburst;
  logic                      axi_arvalid;
  logic                      axi_arready;

  logic [AXI_ID_WIDTH-1:0]   axi_rid;
  logic [AXI_DATA_WIDTH-1:0] axi_rdata;
  logic [1:0]                axi_rresp;
  logic                      axi_rlast;
  logic                      axi_rvalid;
  logic                      axi_rready;

  modport slave (
    input  axi_awid, axi_awaddr, axi_awlen, axi_awburst, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_wready,
    output axi_bid, axi_bresp, axi_bvalid,
    input  axi_bready,
    input  axi_arid, axi_araddr, axi_arlen, axi_arburst, axi_arvalid,
    output axi_arready,
    output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    input  axi_rready
  );

  modport master (
    output axi_awid, axi_awaddr, axi_awlen, axi_awburst, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_wready,
    input  axi_bid, axi_bresp, axi_bvalid,
    output axi_bready,
    output axi_arid, axi_araddr, axi_arlen, axi_arburst, axi_arvalid,
    input  axi_arready,
    input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    output axi_rready
  );

endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by an internal word-addressed memory.
// Independent write (AW/W/B) and read (AR/R) FSMs, one outstanding
// transaction each; FIXED and INCR bursts, index wraps at memory depth.
// Ports: clk, rst (async active-high), axi (axi_mem_responder_if.slave).
module axi_mem_responder #(
  parameter int unsigned AXI_ID_WIDTH   = 5,
  parameter int unsigned AXI_LEN_WIDTH  = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned MEM_AWIDTH     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_mem_responder_if.slave   axi
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned BS     = $clog2(STRB_W);
  localparam int unsigned DEPTH  = 2 ** MEM_AWIDTH;

  typedef logic [MEM_AWIDTH-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Byte address to word index; low and upper bits are dropped.
  function automatic idx_t addr_to_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
    return a[BS +: MEM_AWIDTH];
  endfunction

  // FIXED holds the index, everything else increments with wrap.
  function automatic idx_t next_idx(input idx_t i, input logic [1:0] burst);
    return (burst == 2'b00) ? i : idx_t'(i + idx_t'(1));
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

  // Write path state
  w_state_t                 w_state_q, w_state_d;
  logic [AXI_ID_WIDTH-1:0]  w_id_q, w_id_d;
  idx_t                     w_idx_q, w_idx_d;
  logic [AXI_LEN_WIDTH-1:0] w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [1:0]               w_burst_q, w_burst_d;
  logic                     w_err_q, w_err_d;
  logic                     awready_q, awready_d, wready_q, wready_d;
  logic                     bvalid_q, bvalid_d;
  logic [AXI_ID_WIDTH-1:0]  bid_q, bid_d;
  logic [1:0]               bresp_q, bresp_d;
  logic                     mem_we;

  // Read path state
  r_state_t                  r_state_q, r_state_d;
  idx_t                      r_idx_q, r_idx_d;
  logic [AXI_LEN_WIDTH-1:0]  r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [1:0]                r_burst_q, r_burst_d;
  logic                      arready_q, arready_d, rvalid_q, rvalid_d;
  logic                      rlast_q, rlast_d;
  logic [AXI_ID_WIDTH-1:0]   rid_q, rid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi.axi_awaddr, axi.axi_araddr};

  // Write FSM: next state and next registered outputs
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_burst_d = w_burst_q;
    w_err_d   = w_err_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (axi.axi_awvalid && awready_q) begin
          w_id_d    = axi.axi_awid;
          w_idx_d   = addr_to_idx(axi.axi_awaddr);
          w_len_d   = axi.axi_awlen;
          w_burst_d = axi.axi_awburst;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (axi.axi_wvalid && wready_q) begin
          mem_we  = 1'b1;
          // wlast must coincide exactly with the awlen-derived final beat
          w_err_d = w_err_q | (axi.axi_wlast != (w_cnt_q == w_len_q));
          w_idx_d = next_idx(w_idx_q, w_burst_q);
          if (w_cnt_q == w_len_q) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = w_id_q;
            bresp_d   = w_err_d ? 2'b10 : 2'b00;
            w_state_d = W_RESP;
          end else begin
            w_cnt_d = w_cnt_q + AXI_LEN_WIDTH'(1);
          end
        end
      end
      W_RESP: begin
        if (axi.axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Memory byte-lane write; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (axi.axi_wstrb[b]) mem[w_idx_q][b*8 +: 8] <= axi.axi_wdata[b*8 +: 8];
      end
    end
  end

  // Read FSM: data for the next beat is loaded on the accepting edge,
  // so a same-edge write to that word is seen only by later beats.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_burst_d = r_burst_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (axi.axi_arvalid && arready_q) begin
          r_idx_d   = addr_to_idx(axi.axi_araddr);
          r_len_d   = axi.axi_arlen;
          r_burst_d = axi.axi_arburst;
          r_cnt_d   = '0;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rid_d     = axi.axi_arid;
          rdata_d   = mem[r_idx_d];
          rlast_d   = (axi.axi_arlen == '0);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (axi.axi_rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            r_idx_d = next_idx(r_idx_q, r_burst_q);
            r_cnt_d = r_cnt_q + AXI_LEN_WIDTH'(1);
            rdata_d = mem[r_idx_d];
            rlast_d = (r_cnt_d == r_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_burst_q <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_burst_q <= r_burst_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign axi.axi_awready = awready_q;
  assign axi.axi_wready  = wready_q;
  assign axi.axi_bvalid  = bvalid_q;
  assign axi.axi_bid     = bid_q;
  assign axi.axi_bresp   = bresp_q;
  assign axi.axi_arready = arready_q;
  assign axi.axi_rvalid  = rvalid_q;
  assign axi.axi_rlast   = rlast_q;
  assign axi.axi_rid     = rid_q;
  assign axi.axi_rdata   = rdata_q;
  assign axi.axi_rresp   = 2'b00;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder with a 16-word memory.
module tb_axi_mem_responder;

  localparam int unsigned IDW = 5, LW = 4, AW = 32, DW = 64, MAW = 4;
  localparam int TMO = 60;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_mem_responder_if #(.AXI_ID_WIDTH(IDW), .AXI_LEN_WIDTH(LW),
                         .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) axi ();

  axi_mem_responder #(.AXI_ID_WIDTH(IDW), .AXI_LEN_WIDTH(LW), .AXI_ADDR_WIDTH(AW),
                      .AXI_DATA_WIDTH(DW), .MEM_AWIDTH(MAW))
    dut (.clk(clk), .rst(rst), .axi(axi));

  int checks = 0;
  int errors = 0;

  // Reference memory: word = (byte address / 8) mod 16
  logic [63:0] model_mem [16];
  logic [63:0] wr_data [16];
  logic [7:0]  wr_strb [16];
  logic [63:0] rd_data [16];
  logic [15:0] rd_last;
  int          rd_beats, rd_lat;
  logic [4:0]  rd_id;
  bit          rd_stable, rd_resp_ok;

  function automatic int word_of(input logic [31:0] addr, input logic [1:0] burst, input int beat);
    int base = int'((addr / 32'd8) % 32'd16);
    return (burst == 2'b00) ? base : (base + beat) % 16;
  endfunction

  task automatic model_write(input logic [31:0] addr, input int len, input logic [1:0] burst);
    for (int b = 0; b <= len; b++)
      for (int k = 0; k < 8; k++)
        if (wr_strb[b][k]) model_mem[word_of(addr, burst, b)][k*8 +: 8] = wr_data[b][k*8 +: 8];
  endtask

  task automatic idle_bus();
    axi.axi_awid = '0; axi.axi_awaddr = '0; axi.axi_awlen = '0; axi.axi_awburst = 2'b01;
    axi.axi_awvalid = 1'b0; axi.axi_wdata = '0; axi.axi_wstrb = '0; axi.axi_wlast = 1'b0;
    axi.axi_wvalid = 1'b0; axi.axi_bready = 1'b0; axi.axi_arid = '0; axi.axi_araddr = '0;
    axi.axi_arlen = '0; axi.axi_arburst = 2'b01; axi.axi_arvalid = 1'b0; axi.axi_rready = 1'b0;
  endtask

  task automatic write_burst(input logic [4:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input int wlast_beat, input int bready_delay,
                             output logic [4:0] bid, output logic [1:0] bresp, output bit b_stable);
    int n;
    @(negedge clk);
    axi.axi_awid = id; axi.axi_awaddr = addr; axi.axi_awlen = LW'(len);
    axi.axi_awburst = burst; axi.axi_awvalid = 1'b1;
    n = 0;
    while (!axi.axi_awready && n < TMO) begin @(negedge clk); n++; end
    checks++;
    if (n >= TMO) begin errors++; $display("FAIL aw_handshake awready=0 required 1"); end
    @(negedge clk);
    axi.axi_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      axi.axi_wdata = wr_data[b]; axi.axi_wstrb = wr_strb[b];
      axi.axi_wlast = (b == wlast_beat); axi.axi_wvalid = 1'b1;
      n = 0;
      while (!axi.axi_wready && n < TMO) begin @(negedge clk); n++; end
      checks++;
      if (n >= TMO) begin errors++; $display("FAIL w_handshake beat %0d wready=0 required 1", b); end
      @(negedge clk);
    end
    axi.axi_wvalid = 1'b0; axi.axi_wlast = 1'b0;
    n = 0;
    while (!axi.axi_bvalid && n < TMO) begin @(negedge clk); n++; end
    checks++;
    if (n >= TMO) begin errors++; $display("FAIL b_wait bvalid=0 required 1"); end
    bid = axi.axi_bid; bresp = axi.axi_bresp; b_stable = 1'b1;
    repeat (bready_delay) begin
      @(negedge clk);
      if (axi.axi_bvalid !== 1'b1 || axi.axi_bid !== bid || axi.axi_bresp !== bresp) b_stable = 1'b0;
    end
    axi.axi_bready = 1'b1;
    @(negedge clk);
    axi.axi_bready = 1'b0;
  endtask

  task automatic read_burst(input logic [4:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int stall_pct);
    int n;
    bit held, done;
    logic [63:0] h_data;
    logic h_last;
    logic [4:0] h_id;
    @(negedge clk);
    axi.axi_arid = id; axi.axi_araddr = addr; axi.axi_arlen = LW'(len);
    axi.axi_arburst = burst; axi.axi_arvalid = 1'b1;
    n = 0;
    while (!axi.axi_arready && n < TMO) begin @(negedge clk); n++; end
    checks++;
    if (n >= TMO) begin errors++; $display("FAIL ar_handshake arready=0 required 1"); end
    @(negedge clk);
    axi.axi_arvalid = 1'b0;
    rd_lat = 0;
    while (!axi.axi_rvalid && rd_lat < TMO) begin @(negedge clk); rd_lat++; end
    rd_beats = 0; rd_last = '0; rd_stable = 1'b1; rd_resp_ok = 1'b1; rd_id = 'x;
    held = 1'b0; done = 1'b0; h_data = '0; h_last = 1'b0; h_id = '0;
    n = 0;
    while (!done && n < 200) begin
      if (axi.axi_rvalid) begin
        if (held && (axi.axi_rdata !== h_data || axi.axi_rlast !== h_last || axi.axi_rid !== h_id))
          rd_stable = 1'b0;
        if (axi.axi_rresp !== 2'b00) rd_resp_ok = 1'b0;
        axi.axi_rready = ($urandom_range(0, 99) >= stall_pct);
        if (axi.axi_rready) begin
          if (rd_beats < 16) begin
            rd_data[rd_beats] = axi.axi_rdata;
            rd_last[rd_beats] = axi.axi_rlast;
          end
          if (rd_beats == 0) rd_id = axi.axi_rid;
          rd_beats++;
          held = 1'b0;
          done = (axi.axi_rlast === 1'b1) || (rd_beats > 16);
        end else begin
          held = 1'b1; h_data = axi.axi_rdata; h_last = axi.axi_rlast; h_id = axi.axi_rid;
        end
      end else begin
        axi.axi_rready = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    axi.axi_rready = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL r_wait rlast never seen, beats=%0d required %0d", rd_beats, len + 1); end
  endtask

  // Compares one completed read against the model (beats, data, rlast, ID, stalls)
  task automatic check_read(input string tag, input logic [4:0] id, input logic [31:0] addr,
                            input int len, input logic [1:0] burst);
    logic [15:0] exp_last;
    exp_last = '0;
    exp_last[len] = 1'b1;
    checks++;
    if (rd_beats !== len + 1) begin errors++; $display("FAIL %s_beats got %0d required %0d", tag, rd_beats, len + 1); end
    for (int b = 0; b <= len; b++) begin
      checks++;
      if (rd_data[b] !== model_mem[word_of(addr, burst, b)]) begin
        errors++; $display("FAIL %s_rdata beat %0d got %h required %h", tag, b, rd_data[b], model_mem[word_of(addr, burst, b)]);
      end
    end
    checks++;
    if (rd_last !== exp_last) begin errors++; $display("FAIL %s_rlast got %b required %b", tag, rd_last, exp_last); end
    checks++;
    if (rd_id !== id || !rd_stable || !rd_resp_ok || rd_lat !== 0) begin
      errors++; $display("FAIL %s_rid_stable rid=%h stable=%0d resp_ok=%0d lat=%0d required %h 1 1 0", tag, rd_id, rd_stable, rd_resp_ok, rd_lat, id);
    end
  endtask

  task automatic test_reset();
    idle_bus();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({axi.axi_awready, axi.axi_arready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready got %b required 11", {axi.axi_awready, axi.axi_arready});
    end
    checks++;
    if ({axi.axi_wready, axi.axi_bvalid, axi.axi_rvalid, axi.axi_rlast} !== 4'b0000) begin
      errors++; $display("FAIL reset_valids got %b required 0000", {axi.axi_wready, axi.axi_bvalid, axi.axi_rvalid, axi.axi_rlast});
    end
    checks++;
    if ({axi.axi_bid, axi.axi_bresp, axi.axi_rid, axi.axi_rresp} !== 14'd0 || axi.axi_rdata !== 64'd0) begin
      errors++; $display("FAIL reset_fields bid=%h bresp=%h rid=%h rresp=%h rdata=%h required all 0",
                         axi.axi_bid, axi.axi_bresp, axi.axi_rid, axi.axi_rresp, axi.axi_rdata);
    end
  endtask

  task automatic test_preload();
    logic [4:0] bid; logic [1:0] bresp; bit bs;
    for (int i = 0; i < 16; i++) begin wr_data[i] = {$urandom, $urandom}; wr_strb[i] = 8'hFF; end
    write_burst(5'h11, 32'h0, 15, 2'b01, 15, 0, bid, bresp, bs);
    model_write(32'h0, 15, 2'b01);
    checks++;
    if (bresp !== 2'b00 || bid !== 5'h11) begin errors++; $display("FAIL preload_b bid=%h bresp=%b required 11 00", bid, bresp); end
    read_burst(5'h12, 32'h0, 15, 2'b01, 30);
    check_read("preload", 5'h12, 32'h0, 15, 2'b01);
  endtask

  task automatic test_single();
    logic [4:0] bid; logic [1:0] bresp; bit bs;
    wr_data[0] = 64'h1122334455667788; wr_strb[0] = 8'hFF;
    write_burst(5'h03, 32'h40, 0, 2'b01, 0, 0, bid, bresp, bs);
    model_write(32'h40, 0, 2'b01);
    checks++;
    if (bresp !== 2'b00 || bid !== 5'h03) begin errors++; $display("FAIL single_b bid=%h bresp=%b required 03 00", bid, bresp); end
    checks++;
    if (axi.axi_awready !== 1'b1) begin errors++; $display("FAIL single_awready_after_b got %b required 1", axi.axi_awready); end
    read_burst(5'h07, 32'h40, 0, 2'b01, 0);
    checks++;
    if (rd_data[0] !== 64'h1122334455667788 || rd_last[0] !== 1'b1 || rd_id !== 5'h07) begin
      errors++; $display("FAIL single_read rdata=%h rlast=%b rid=%h required 1122334455667788 1 07", rd_data[0], rd_last[0], rd_id);
    end
  endtask

  task automatic test_incr_burst();
    logic [4:0] bid; logic [1:0] bresp; bit bs;
    for (int i = 0; i < 4; i++) begin wr_data[i] = 64'(i + 1); wr_strb[i] = 8'hFF; end
    write_burst(5'h0A, 32'h0, 3, 2'b01, 3, 5, bid, bresp, bs);
    model_write(32'h0, 3, 2'b01);
    checks++;
    if (bresp !== 2'b00 || bid !== 5'h0A || !bs) begin
      errors++; $display("FAIL incr_b bid=%h bresp=%b stable=%0d required 0a 00 1", bid, bresp, bs);
    end
    read_burst(5'h0B, 32'h0, 3, 2'b01, 0);
    check_read("incr", 5'h0B, 32'h0, 3, 2'b01);
    checks++;
    if (rd_data[3] !== 64'd4) begin errors++; $display("FAIL incr_beat4 got %h required 4", rd_data[3]); end
  endtask

  task automatic test_strobes();
    logic [4:0] bid; logic [1:0] bresp; bit bs;
    wr_data[0] = 64'hFFFFFFFFFFFFFFFF; wr_strb[0] = 8'hFF;
    write_burst(5'h01, 32'h0, 0, 2'b01, 0, 0, bid, bresp, bs);
    model_write(32'h0, 0, 2'b01);
    wr_data[0] = 64'h0; wr_strb[0] = 8'h0F;
    write_burst(5'h02, 32'h0, 0, 2'b01, 0, 0, bid, bresp, bs);
    model_write(32'h0, 0, 2'b01);
    read_burst(5'h03, 32'h0, 0, 2'b01, 0);
    checks++;
    if (rd_data[0] !== 64'hFFFFFFFF00000000) begin errors++; $display("FAIL strobe_merge got %h required ffffffff00000000", rd_data[0]); end
  endtask

  task automatic test_wrap_fixed();
    logic [4:0] bid; logic [1:0] bresp; bit bs;
    for (int i = 0; i < 3; i++) begin wr_data[i] = {$urandom, $urandom}; wr_strb[i] = 8'hFF; end
    // word 15 with upper address bits set: second beat must wrap to word 0
    write_burst(5'h04, 32'h1000_0078, 1, 2'b01, 1, 0, bid, bresp, bs);
    model_write(32'h1000_0078, 1, 2'b01);
    read_burst(5'h05, 32'h0, 0, 2'b01, 0);
    checks++;
    if (rd_data[0] !== wr_data[1]) begin errors++; $display("FAIL wrap_word0 got %h required %h", rd_data[0], wr_data[1]); end
    read_burst(5'h06, 32'h78, 1, 2'b11, 20);
    check_read("wrap", 5'h06, 32'h78, 1, 2'b11);
    for (int i = 0; i < 3; i++) wr_data[i] = {$urandom, $urandom};
    write_burst(5'h08, 32'h28, 2, 2'b00, 2, 0, bid, bresp, bs);
    model_write(32'h28, 2, 2'b00);
    read_burst(5'h09, 32'h28, 2, 2'b00, 20);
    checks++;
    if (rd_data[0] !== wr_data[2]) begin errors++; $display("FAIL fixed_last_wins got %h required %h", rd_data[0], wr_data[2]); end
    check_read("fixed", 5'h09, 32'h28, 2, 2'b00);
  endtask

  task automatic test_protocol_errors();
    logic [4:0] bid; logic [1:0] bresp; bit bs;
    for (int i = 0; i < 4; i++) begin wr_data[i] = {$urandom, $urandom}; wr_strb[i] = 8'hFF; end
    write_burst(5'h0C, 32'h20, 3, 2'b01, 1, 0, bid, bresp, bs);
    model_write(32'h20, 3, 2'b01);
    checks++;
    if (bresp !== 2'b10 || bid !== 5'h0C) begin errors++; $display("FAIL early_wlast_bresp got %b id %h required 10 0c", bresp, bid); end
    read_burst(5'h0D, 32'h20, 3, 2'b01, 0);
    check_read("early_wlast", 5'h0D, 32'h20, 3, 2'b01);
    for (int i = 0; i < 3; i++) wr_data[i] = {$urandom, $urandom};
    write_burst(5'h0E, 32'h60, 2, 2'b01, -1, 2, bid, bresp, bs);
    model_write(32'h60, 2, 2'b01);
    checks++;
    if (bresp !== 2'b10 || !bs) begin errors++; $display("FAIL no_wlast_bresp got %b stable %0d required 10 1", bresp, bs); end
    write_burst(5'h0F, 32'h60, 0, 2'b01, 0, 0, bid, bresp, bs);
    model_write(32'h60, 0, 2'b01);
    checks++;
    if (bresp !== 2'b00) begin errors++; $display("FAIL error_cleared_bresp got %b required 00", bresp); end
  endtask

  task automatic test_concurrent();
    logic [4:0] bid; logic [1:0] bresp; bit bs;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) begin wr_data[i] = {$urandom, $urandom}; wr_strb[i] = 8'($urandom); end
      fork
        write_burst(5'(r + 16), 32'h40, 3, 2'b01, 3, int'($urandom_range(0, 3)), bid, bresp, bs);
        read_burst(5'(r), 32'h0, 3, 2'b01, 40);
      join
      check_read("concurrent", 5'(r), 32'h0, 3, 2'b01);
      model_write(32'h40, 3, 2'b01);
      checks++;
      if (bresp !== 2'b00 || bid !== 5'(r + 16)) begin errors++; $display("FAIL concurrent_b bid=%h bresp=%b required %h 00", bid, bresp, 5'(r + 16)); end
      read_burst(5'h1F, 32'h40, 3, 2'b01, 25);
      check_read("concurrent_wb", 5'h1F, 32'h40, 3, 2'b01);
    end
  endtask

  task automatic test_random();
    logic [4:0] bid; logic [1:0] bresp; bit bs;
    logic [31:0] addr; int len; logic [1:0] burst; logic [4:0] id;
    for (int r = 0; r < 8; r++) begin
      addr = $urandom; len = int'($urandom_range(0, 15)); burst = 2'($urandom); id = 5'($urandom);
      for (int i = 0; i <= len; i++) begin wr_data[i] = {$urandom, $urandom}; wr_strb[i] = 8'($urandom); end
      write_burst(id, addr, len, burst, len, int'($urandom_range(0, 2)), bid, bresp, bs);
      model_write(addr, len, burst);
      checks++;
      if (bresp !== 2'b00 || bid !== id) begin errors++; $display("FAIL random_b bid=%h bresp=%b required %h 00", bid, bresp, id); end
      read_burst(~id, addr, len, burst, 35);
      check_read("random", ~id, addr, len, burst);
    end
  endtask

  task automatic test_reset_mid_read();
    bit stray;
    @(negedge clk);
    axi.axi_arid = 5'h15; axi.axi_araddr = 32'h0; axi.axi_arlen = 4'd3;
    axi.axi_arburst = 2'b01; axi.axi_arvalid = 1'b1;
    @(negedge clk);
    axi.axi_arvalid = 1'b0;
    checks++;
    if (axi.axi_rvalid !== 1'b1 || axi.axi_rdata !== model_mem[0]) begin
      errors++; $display("FAIL rstmid_beat1 rvalid=%b rdata=%h required 1 %h", axi.axi_rvalid, axi.axi_rdata, model_mem[0]);
    end
    axi.axi_rready = 1'b1;
    @(negedge clk);
    axi.axi_rready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (axi.axi_rvalid !== 1'b0 || axi.axi_rlast !== 1'b0) begin
      errors++; $display("FAIL rstmid_async rvalid=%b rlast=%b required 0 0", axi.axi_rvalid, axi.axi_rlast);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (axi.axi_arready !== 1'b1 || axi.axi_awready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready arready=%b awready=%b required 1 1", axi.axi_arready, axi.axi_awready);
    end
    stray = 1'b0;
    axi.axi_rready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (axi.axi_rvalid !== 1'b0 || axi.axi_rlast !== 1'b0) stray = 1'b1;
    end
    axi.axi_rready = 1'b0;
    checks++;
    if (stray) begin errors++; $display("FAIL rstmid_stray_beat rvalid/rlast seen after reset, required none"); end
    read_burst(5'h16, 32'h0, 3, 2'b01, 10);
    check_read("after_reset", 5'h16, 32'h0, 3, 2'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_preload();
    test_single();
    test_incr_burst();
    test_strobes();
    test_wrap_fixed();
    test_protocol_errors();
    test_concurrent();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 slave (responder) backed by an internal word-addressed memory.
- Sits at the far end of the AXI master port driven by the axis streaming engine. It stands in for the HP/DDR port in simulation and in loopback test builds.
- Accepts write bursts on AW/W and acknowledges them on B. Serves read bursts on AR/R.
- Write and read paths are independent and may run concurrently.

Parameters:
- AXI_ID_WIDTH, 5, width of the ID fields (awid/bid/arid/rid).
- AXI_LEN_WIDTH, 4, width of awlen/arlen. A burst has len+1 beats, at most 16.
- AXI_ADDR_WIDTH, 32, byte address width.
- AXI_DATA_WIDTH, 64, data width. Legal values: 32, 64, 128.
- MEM_AWIDTH, 10, log2 of the memory depth in AXI_DATA_WIDTH words.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- axi_awid  in  AXI_ID_WIDTH  write ID.
- axi_awaddr  in  AXI_ADDR_WIDTH  write start byte address.
- axi_awlen  in  AXI_LEN_WIDTH  write beats minus 1.
- axi_awburst  in  2  burst type: 0 FIXED, 1 INCR; other codes treated as INCR.
- axi_awvalid  in  1  / axi_awready  out  1  AW handshake.
- axi_wdata  in  AXI_DATA_WIDTH  write data.
- axi_wstrb  in  AXI_DATA_WIDTH/8  byte enables.
- axi_wlast  in  1  last write beat.
- axi_wvalid  in  1  / axi_wready  out  1  W handshake.
- axi_bid  out  AXI_ID_WIDTH  / axi_bresp  out  2  write response.
- axi_bvalid  out  1  / axi_bready  in  1  B handshake.
- axi_arid  in  AXI_ID_WIDTH  / axi_araddr  in  AXI_ADDR_WIDTH  / axi_arlen  in  AXI_LEN_WIDTH  / axi_arburst  in  2  read request.
- axi_arvalid  in  1  / axi_arready  out  1  AR handshake.
- axi_rid  out  AXI_ID_WIDTH  / axi_rdata  out  AXI_DATA_WIDTH  / axi_rresp  out  2  / axi_rlast  out  1  read data.
- axi_rvalid  out  1  / axi_rready  in  1  R handshake.

Behaviour:
- Addressing:
  - Word index = addr[BS+MEM_AWIDTH-1:BS], where BS = log2(AXI_DATA_WIDTH/8).
  - Low BS address bits are ignored (aligned accesses only).
  - Upper address bits are ignored; the index wraps modulo 2^MEM_AWIDTH.
  - INCR bursts: index +1 per beat, wrapping from 2^MEM_AWIDTH-1 to 0. FIXED bursts: index held constant.
- Reset (async assert, sampled deassert):
  - Both FSMs return to IDLE.
  - Outputs: awready=1, arready=1; wready, bvalid, rvalid, rlast = 0; bid, bresp, rid, rresp, rdata = 0.
  - Memory contents are not reset.
  - Reset mid-burst abandons the burst; no B or R beat is issued for it.
- Write FSM (W_IDLE, W_DATA, W_RESP):
  - W_IDLE: awready=1. On awvalid, capture awid, index, awlen, awburst; clear beat count and error flag; go to W_DATA next cycle.
  - W_DATA: wready=1, awready=0.
    - Each W handshake writes the bytes enabled by wstrb at the current index on that edge, then advances the index.
    - Error flag is set if wlast != (beat count == len).
    - After len+1 beats (counted from awlen, not from wlast), go to W_RESP.
  - W_RESP: bvalid=1, bid = captured ID, bresp = 2'b10 (SLVERR) if the error flag is set, else 2'b00.
    - Hold bid/bresp stable until bready.
    - On the bvalid & bready edge, go to W_IDLE with awready=1 the next cycle.
  - Minimum burst: AW accept edge, first W beat accepted one cycle later, bvalid asserted the cycle after the last beat.
  - AW is not accepted again until B completes (one outstanding write).
- Read FSM (R_IDLE, R_DATA):
  - R_IDLE: arready=1. On arvalid, capture arid, index, arlen, arburst.
  - Next cycle: rvalid=1, rdata = mem[start index], rlast = (arlen==0). One cycle of AR-to-R latency.
  - R_DATA: rid, rdata, rlast held stable while rvalid & !rready.
    - On a handshake with rlast=0, load the next beat's data into rdata on the same edge, so back-to-back beats run at 1 per cycle.
    - On a handshake with rlast=1: rvalid=0, return to R_IDLE, arready=1 the next cycle.
  - rresp is always 2'b00. One outstanding read.
- Read/write collision:
  - A read beat loaded on the same edge as a write to the same index returns the pre-write value.
  - A write completed on an earlier edge is visible to all later reads.
- AW and AR may be accepted in the same cycle; the two paths have no ordering relation.

Test Plan:
- Single write then read: write awaddr=0x40, awlen=0, wdata=0x1122334455667788, wstrb=0xFF, wlast=1; then read araddr=0x40, arlen=0 -> bresp=0, rdata=0x1122334455667788, rlast=1 on the only beat, bid/rid echo IDs 5'h03/5'h07.
- INCR burst: write awlen=3 at 0x0 with data 1,2,3,4, bready held low 5 cycles -> bvalid and bid held stable throughout; read arlen=3 at 0x0 with rready=1 -> 4 consecutive R beats returning 1,2,3,4, rlast only on beat 4.
- Byte strobes: preload word 0xFFFFFFFFFFFFFFFF, write 0x0 with wstrb=0x0F -> readback 0xFFFFFFFF00000000.
- Wrap and FIXED: MEM_AWIDTH=4, INCR write awlen=1 at word 15 -> second beat lands in word 0; FIXED write awlen=2 with data A,B,C -> word holds C.
- Protocol errors: wlast asserted on beat 2 of a 4-beat burst -> all 4 beats still accepted, bresp=2'b10; wlast never asserted -> bresp=2'b10.
- Concurrency/reset: R burst with random rready stalls while a write runs -> R data stable during stalls, streams unaffected; assert rst during beat 2 of a read -> rvalid=0 immediately, arready=1 after deassert, no stray rlast.
